mac32_txn_tracker: RTL and testbench

- Sits between the mac32 DUT ports and the scoreboard.
- Records every operand triple (A_i, B_i, C_i) issued to the DUT in an in-order FIFO, with a transaction id and an issue timestamp.
- When the DUT produces a result, pairs it with the oldest outstanding triple and presents {A, B, C, Result, id, latency} to the scoreboard over a valid/ready handshake.
- Detects overflow, orphan results, dropped transactions and DUT timeouts.

---
 rtl/mac32_tb_pkg.sv | 35 +++
 rtl/mac32_op_fifo.sv | 80 ++++++++
 rtl/mac32_txn_tracker.sv | 143 ++++++++++++++
 tb/tb_mac32_txn_tracker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac32_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac32_tb_pkg
// Description : Shared widths, the recorded-operand entry type and the
//               sticky error-flag vector used by the mac32 transaction
//               tracker and its operand FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mac32_tb_pkg;

  localparam int unsigned MAC32_XLEN    = 32;  // operand/result width
  localparam int unsigned MAC32_DEPTH   = 8;   // outstanding transactions
  localparam int unsigned MAC32_TIMEOUT = 16;  // head retire age in cycles
  localparam int unsigned MAC32_TSW     = 16;  // timestamp/latency width
  localparam int unsigned MAC32_IDW     = 8;   // transaction id width

  // One issued operand triple plus its bookkeeping.
  typedef struct packed {
    logic [MAC32_XLEN-1:0] a;
    logic [MAC32_XLEN-1:0] b;
    logic [MAC32_XLEN-1:0] c;
    logic [MAC32_IDW-1:0]  id;
    logic [MAC32_TSW-1:0]  ts;
  } mac32_txn_t;

  // Sticky error flags, cleared only by reset.
  typedef struct packed {
    logic overflow;
    logic orphan;
    logic drop;
    logic timeout;
  } mac32_err_t;

endpackage : mac32_tb_pkg
`default_nettype wire

// File: rtl/mac32_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mac32_op_fifo
// Description : In-order synchronous FIFO of mac32_txn_t entries. The head
//               entry is presented combinationally. A push into a full FIFO
//               is accepted when a pop happens in the same cycle.
// Ports       : clk, rst_n     - clock, async active-low reset
//               push_i, data_i - write request and entry
//               pop_i          - remove head (ignored when empty)
//               full_o/empty_o - status from current occupancy
//               count_o        - registered occupancy
//               head_o         - oldest entry (undefined when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module mac32_op_fifo
  import mac32_tb_pkg::*;
#(
  parameter int unsigned PARM_DEPTH = MAC32_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push_i,
  input  mac32_txn_t                        data_i,
  input  logic                              pop_i,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [$clog2(PARM_DEPTH+1)-1:0]   count_o,
  output mac32_txn_t                        head_o
);

  localparam int unsigned AW = (PARM_DEPTH > 1) ? $clog2(PARM_DEPTH) : 1;
  localparam int unsigned CW = $clog2(PARM_DEPTH + 1);

  mac32_txn_t        mem_q [PARM_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(PARM_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // When full, the slot being written is the one the pop frees this cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads past the valid occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : mac32_op_fifo
`default_nettype wire

// File: rtl/mac32_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mac32_txn_tracker
// Description : Records operand triples issued to a mac32 DUT, pairs each DUT
//               result with the oldest outstanding triple and offers the
//               paired transaction over valid/ready. Flags overflow, orphan
//               results, dropped pairings and timed-out heads (sticky).
// Ports       : clk, rst_n                 - clock, async active-low reset
//               in_valid_i, A_i/B_i/C_i    - operand issue
//               dut_valid_i, Result_i      - DUT result
//               txn_valid_o, txn_ready_i   - output handshake
//               txn_A/B/C/Result/id/latency_o - paired transaction
//               inflight_o                 - outstanding entry count
//               err_*_o                    - sticky error flags
// Note        : Entry field widths come from mac32_tb_pkg; the width
//               parameters here must stay equal to the package values.
// Revision    : 1.0 - initial release
// ============================================================================
module mac32_txn_tracker
  import mac32_tb_pkg::*;
#(
  parameter int unsigned PARM_XLEN    = MAC32_XLEN,
  parameter int unsigned PARM_DEPTH   = MAC32_DEPTH,
  parameter int unsigned PARM_TIMEOUT = MAC32_TIMEOUT,
  parameter int unsigned PARM_TSW     = MAC32_TSW,
  parameter int unsigned PARM_IDW     = MAC32_IDW
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid_i,
  input  logic [PARM_XLEN-1:0]             A_i,
  input  logic [PARM_XLEN-1:0]             B_i,
  input  logic [PARM_XLEN-1:0]             C_i,
  input  logic                             dut_valid_i,
  input  logic [PARM_XLEN-1:0]             Result_i,
  output logic                             txn_valid_o,
  input  logic                             txn_ready_i,
  output logic [PARM_XLEN-1:0]             txn_A_o,
  output logic [PARM_XLEN-1:0]             txn_B_o,
  output logic [PARM_XLEN-1:0]             txn_C_o,
  output logic [PARM_XLEN-1:0]             txn_Result_o,
  output logic [PARM_IDW-1:0]              txn_id_o,
  output logic [PARM_TSW-1:0]              txn_latency_o,
  output logic [$clog2(PARM_DEPTH+1)-1:0]  inflight_o,
  output logic                             err_overflow_o,
  output logic                             err_orphan_o,
  output logic                             err_drop_o,
  output logic                             err_timeout_o
);

  logic [PARM_TSW-1:0]  cycle_q;
  logic [PARM_IDW-1:0]  id_q;
  logic                 txn_valid_q, txn_valid_d;
  mac32_txn_t           txn_q, txn_d;       // ts field carries latency
  logic [PARM_XLEN-1:0] result_q, result_d;
  mac32_err_t           err_q, err_d;

  logic                 fifo_full, fifo_empty;
  mac32_txn_t           head, push_entry;
  logic [PARM_TSW-1:0]  head_age;
  logic                 pop, orphan, retire, remove, push_ok, overflow;
  logic                 hold, load;

  assign head_age = cycle_q - head.ts;
  assign pop      = dut_valid_i & ~fifo_empty;
  assign orphan   = dut_valid_i & fifo_empty;
  // A result always wins over retire, so at most one removal per cycle.
  assign retire   = ~fifo_empty & ~dut_valid_i &
                    (head_age >= PARM_TSW'(PARM_TIMEOUT));
  assign remove   = pop | retire;
  assign push_ok  = in_valid_i & (~fifo_full | remove);
  assign overflow = in_valid_i & fifo_full & ~remove;
  // A stalled output keeps its data; a new pairing in that cycle is lost.
  assign hold     = txn_valid_q & ~txn_ready_i;
  assign load     = pop & ~hold;

  assign push_entry = '{a: A_i, b: B_i, c: C_i, id: id_q, ts: cycle_q};

  mac32_op_fifo #(
    .PARM_DEPTH (PARM_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .data_i  (push_entry),
    .pop_i   (remove),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (inflight_o),
    .head_o  (head)
  );

  always_comb begin
    txn_valid_d = txn_valid_q;
    txn_d       = txn_q;
    result_d    = result_q;
    if (load) begin
      txn_valid_d = 1'b1;
      txn_d       = head;
      txn_d.ts    = head_age;
      result_d    = Result_i;
    end else if (txn_valid_q && txn_ready_i) begin
      txn_valid_d = 1'b0;
    end
    err_d          = err_q;
    err_d.overflow = err_q.overflow | overflow;
    err_d.orphan   = err_q.orphan   | orphan;
    err_d.drop     = err_q.drop     | (pop & hold);
    err_d.timeout  = err_q.timeout  | retire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q     <= '0;
      id_q        <= '0;
      txn_valid_q <= 1'b0;
      txn_q       <= '0;
      result_q    <= '0;
      err_q       <= '0;
    end else begin
      cycle_q     <= cycle_q + 1'b1;
      if (push_ok) id_q <= id_q + 1'b1;
      txn_valid_q <= txn_valid_d;
      txn_q       <= txn_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign txn_valid_o    = txn_valid_q;
  assign txn_A_o        = txn_q.a;
  assign txn_B_o        = txn_q.b;
  assign txn_C_o        = txn_q.c;
  assign txn_Result_o   = result_q;
  assign txn_id_o       = txn_q.id;
  assign txn_latency_o  = txn_q.ts;
  assign err_overflow_o = err_q.overflow;
  assign err_orphan_o   = err_q.orphan;
  assign err_drop_o     = err_q.drop;
  assign err_timeout_o  = err_q.timeout;

endmodule : mac32_txn_tracker
`default_nettype wire

// File: tb/tb_mac32_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac32_txn_tracker
// Description : Self-checking bench for mac32_txn_tracker: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac32_txn_tracker;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, dut_valid = 1'b0, ready = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, c_in = '0, res_in = '0;
  logic        txn_valid;
  logic [31:0] txn_a, txn_b, txn_c, txn_r;
  logic [7:0]  txn_id;
  logic [15:0] txn_lat;
  logic [3:0]  inflight;
  logic        e_ov, e_or, e_dr, e_to;

  always #5 clk = ~clk;

  mac32_txn_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .A_i(a_in), .B_i(b_in), .C_i(c_in),
    .dut_valid_i(dut_valid), .Result_i(res_in),
    .txn_valid_o(txn_valid), .txn_ready_i(ready),
    .txn_A_o(txn_a), .txn_B_o(txn_b), .txn_C_o(txn_c), .txn_Result_o(txn_r),
    .txn_id_o(txn_id), .txn_latency_o(txn_lat), .inflight_o(inflight),
    .err_overflow_o(e_ov), .err_orphan_o(e_or), .err_drop_o(e_dr),
    .err_timeout_o(e_to)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int unsigned a, b, c, id, ts; } ent_t;
  ent_t        m_q[$];
  int unsigned m_cycle, m_id, m_a, m_b, m_c, m_r, m_tid, m_lat;
  bit          m_valid, f_ov, f_or, f_dr, f_to;

  function automatic void model_reset();
    m_q.delete();
    m_cycle = 0; m_id = 0; m_valid = 0;
    m_a = 0; m_b = 0; m_c = 0; m_r = 0; m_tid = 0; m_lat = 0;
    f_ov = 0; f_or = 0; f_dr = 0; f_to = 0;
  endfunction

  // Applies the current inputs for one clock cycle.
  function automatic void model_step();
    bit   empty = (m_q.size() == 0);
    bit   full  = (m_q.size() == DEPTH);
    bit   popped = 0, retired = 0;
    ent_t e;
    if (dut_valid && empty) f_or = 1;
    if (!empty && !dut_valid && (((m_cycle - m_q[0].ts) & 32'hFFFF) >= TIMEOUT)) begin
      void'(m_q.pop_front());
      f_to = 1;
      retired = 1;
    end
    if (dut_valid && !empty) begin
      e = m_q.pop_front();
      popped = 1;
      if (m_valid && !ready) f_dr = 1;
      else begin
        m_valid = 1;
        m_a = e.a; m_b = e.b; m_c = e.c; m_r = res_in; m_tid = e.id;
        m_lat = (m_cycle - e.ts) & 32'hFFFF;
      end
    end else if (m_valid && ready) m_valid = 0;
    if (in_valid) begin
      if (full && !popped && !retired) f_ov = 1;
      else begin
        m_q.push_back('{a_in, b_in, c_in, m_id, m_cycle});
        m_id = (m_id + 1) & 32'hFF;
      end
    end
    m_cycle = (m_cycle + 1) & 32'hFFFF;
  endfunction

  task automatic compare();
    check("valid", txn_valid, m_valid);
    check("inflight", inflight, m_q.size());
    check("flags", {e_ov, e_or, e_dr, e_to}, {f_ov, f_or, f_dr, f_to});
    if (m_valid) begin
      check("A", txn_a, m_a);
      check("B", txn_b, m_b);
      check("C", txn_c, m_c);
      check("Result", txn_r, m_r);
      check("id", txn_id, m_tid);
      check("latency", txn_lat, m_lat);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic drive(input bit iv, input bit dv, input bit rdy,
                       input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] ci, input logic [31:0] ri);
    in_valid = iv; dut_valid = dv; ready = rdy;
    a_in = ai; b_in = bi; c_in = ci; res_in = ri;
    step();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, rdy, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    in_valid = 0; dut_valid = 0;
    rst_n = 0;
    #1;
    check("rst_valid", txn_valid, 0);
    check("rst_inflight", inflight, 0);
    check("rst_flags", {e_ov, e_or, e_dr, e_to}, 0);
    check("rst_data", {txn_a, txn_id, txn_lat}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    compare();
  endtask

  int peak;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single transaction
    idle(10, 1);
    drive(1, 0, 1, 32'h3f800000, 32'h40000000, 32'h40400000, 0);
    idle(2, 1);
    drive(0, 1, 1, 0, 0, 0, 32'h40e00000);
    check("single_valid", txn_valid, 1);
    check("single_A", txn_a, 32'h3f800000);
    check("single_R", txn_r, 32'h40e00000);
    check("single_id", txn_id, 0);
    check("single_lat", txn_lat, 3);
    idle(1, 1);
    check("single_clear", txn_valid, 0);

    // Streaming
    do_reset();
    peak = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i < 8, i >= 4, 1, $urandom, $urandom, $urandom, $urandom);
      if (int'(inflight) > peak) peak = int'(inflight);
      if (i >= 4) begin
        check("stream_id", txn_id, i - 4);
        check("stream_lat", txn_lat, 4);
      end
    end
    check("stream_peak", peak, 4);

    // Overflow
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 0, 1, i, i, i, 0);
    check("ovf_before", e_ov, 0);
    drive(1, 0, 1, 32'hDEAD, 32'hDEAD, 32'hDEAD, 0);
    check("ovf_flag", e_ov, 1);
    check("ovf_inflight", inflight, 8);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 0, 0, 0, 100 + i);
      check("ovf_id", txn_id, i);
      check("ovf_A", txn_a, i);
    end
    idle(1, 1);
    check("ovf_drained", inflight, 0);

    // Orphan and same-cycle push into empty FIFO
    do_reset();
    drive(0, 1, 1, 0, 0, 0, 5);
    check("orphan_flag", e_or, 1);
    check("orphan_valid", txn_valid, 0);
    do_reset();
    drive(1, 1, 1, 7, 8, 9, 5);
    check("orphan2_flag", e_or, 1);
    check("orphan2_inflight", inflight, 1);

    // Timeout
    do_reset();
    drive(1, 0, 1, 1, 2, 3, 0);
    idle(TIMEOUT - 1, 1);
    check("tmo_not_yet", {inflight, e_to}, {4'd1, 1'b0});
    idle(1, 1);
    check("tmo_flag", e_to, 1);
    check("tmo_inflight", inflight, 0);
    check("tmo_valid", txn_valid, 0);
    idle(3, 1);
    drive(0, 1, 1, 0, 0, 0, 9);
    check("tmo_orphan", e_or, 1);

    // Backpressure, then reset mid-stream
    do_reset();
    drive(1, 0, 0, 32'h11, 32'h12, 32'h13, 0);
    drive(1, 0, 0, 32'h21, 32'h22, 32'h23, 0);
    idle(3, 0);
    drive(0, 1, 0, 0, 0, 0, 32'hAA);
    drive(0, 1, 0, 0, 0, 0, 32'hBB);
    check("bp_drop", e_dr, 1);
    check("bp_held_A", txn_a, 32'h11);
    check("bp_held_R", txn_r, 32'hAA);
    idle(1, 1);
    check("bp_clear", txn_valid, 0);
    for (int i = 0; i < 5; i++) drive(1, i > 1, 0, i, i, i, i);
    do_reset();

    // Randomized traffic, busy then sparse-result phase
    for (int i = 0; i < 2100; i++) begin
      int p_in  = (i < 1500) ? 50 : 20;
      int p_dv  = (i < 1500) ? 45 : 4;
      int p_rdy = (i < 1500) ? 70 : 50;
      drive($urandom_range(99) < p_in, $urandom_range(99) < p_dv,
            $urandom_range(99) < p_rdy, $urandom, $urandom, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mac32_txn_tracker
`default_nettype wire
